// File: rtl/roll_sequencer.sv
// roll_sequencer: fills the 5-bit random store from a stream, then serves
// d20 rolls (rejection sampling, adv/disadv, saturating mod, target test).
// Ports: clk, reset (async, active-low).
//   Host side: load_start/load_valid/load_data, roll_req/mode/mod/target.
//   Memory side: mem_we/mem_re/mem_addr/mem_wdata out, mem_rdata in.
//   Results: loaded, busy, roll_valid, roll_raw, roll_final, hit, crit, fumble.
module roll_sequencer #(
  parameter int NUM_BITS  = 8,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int RETRY_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic                load_valid,
  input  logic [4:0]          load_data,
  input  logic                roll_req,
  input  logic [1:0]          mode,
  input  logic [NUM_BITS-1:0] mod,
  input  logic [NUM_BITS-1:0] target,
  input  logic [4:0]          mem_rdata,
  output logic                mem_we,
  output logic                mem_re,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [4:0]          mem_wdata,
  output logic                loaded,
  output logic                busy,
  output logic                roll_valid,
  output logic [4:0]          roll_raw,
  output logic [NUM_BITS-1:0] roll_final,
  output logic                hit,
  output logic                crit,
  output logic                fumble
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READY, S_ISSUE, S_CAPTURE, S_EVAL, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [4:0]          face_q, face_d;
  logic                second_q, second_d;
  logic                loaded_q, loaded_d;
  logic [1:0]          mode_q, mode_d;
  logic [NUM_BITS-1:0] mod_q, mod_d;
  logic [NUM_BITS-1:0] tgt_q, tgt_d;

  logic [4:0]          raw_q;
  logic [NUM_BITS-1:0] fin_q;
  logic                hit_q, crit_q, fum_q, vld_q;

  logic                two_dice;
  logic                got;
  logic [4:0]          face_new;
  logic signed [NUM_BITS:0] sum;
  logic [NUM_BITS-1:0] sat;
  logic                hit_c;

  assign two_dice = (mode_q == 2'd1) || (mode_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    pc_d      = pc_q;
    retry_d   = retry_q;
    face_d    = face_q;
    second_d  = second_q;
    loaded_d  = loaded_q;
    mode_d    = mode_q;
    mod_d     = mod_q;
    tgt_d     = tgt_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = 5'd0;
    got       = 1'b0;
    face_new  = 5'd0;
    unique case (state_q)
      S_IDLE, S_READY: begin
        if (load_start) begin
          loaded_d = 1'b0;
          wptr_d   = '0;
          pc_d     = '0;
          state_d  = S_LOAD;
        end else if (state_q == S_READY && roll_req && loaded_q) begin
          mode_d   = mode;
          mod_d    = mod;
          tgt_d    = target;
          retry_d  = '0;
          second_d = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_addr  = wptr_q;
          mem_wdata = load_data;
          wptr_d    = wptr_q + 1'b1;
          if (wptr_q == LAST) begin
            wptr_d   = '0;
            loaded_d = 1'b1;
            state_d  = S_READY;
          end
        end
      end
      S_ISSUE: begin
        mem_re  = 1'b1;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        pc_d = (pc_q == LAST) ? '0 : pc_q + 1'b1;
        if (mem_rdata < 5'd20) begin
          face_new = mem_rdata + 5'd1;
          got      = 1'b1;
          retry_d  = '0;
        end else if (retry_q < RMAX) begin
          retry_d = retry_q + RW'(1);
          state_d = S_ISSUE;
        end else begin
          // out of retries: fold 20..31 onto 1..12
          face_new = mem_rdata - 5'd19;
          got      = 1'b1;
          retry_d  = '0;
        end
        if (got) begin
          if (two_dice && !second_q) begin
            face_d   = face_new;
            second_d = 1'b1;
            state_d  = S_ISSUE;
          end else begin
            face_d  = face_new;
            state_d = S_EVAL;
            if (two_dice) begin
              if (mode_q == 2'd1)
                face_d = (face_new > face_q) ? face_new : face_q;
              else
                face_d = (face_new < face_q) ? face_new : face_q;
            end
          end
        end
      end
      S_EVAL:  state_d = S_DONE;
      S_DONE:  state_d = S_READY;
      default: state_d = S_IDLE;
    endcase
  end

  // one extra bit of headroom, then clamp when the top two bits disagree
  always_comb begin
    sum = $signed({{(NUM_BITS-4){1'b0}}, face_q})
        + $signed({mod_q[NUM_BITS-1], mod_q});
    sat = sum[NUM_BITS-1:0];
    if (sum[NUM_BITS] != sum[NUM_BITS-1])
      sat = sum[NUM_BITS] ? {1'b1, {(NUM_BITS-1){1'b0}}}
                          : {1'b0, {(NUM_BITS-1){1'b1}}};
    hit_c = 1'b0;
    unique case (1'b1)
      (face_q == 5'd20): hit_c = 1'b1;
      (face_q == 5'd1):  hit_c = 1'b0;
      default:           hit_c = $signed(sat) >= $signed(tgt_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      pc_q     <= '0;
      retry_q  <= '0;
      face_q   <= 5'd0;
      second_q <= 1'b0;
      loaded_q <= 1'b0;
      mode_q   <= 2'd0;
      mod_q    <= '0;
      tgt_q    <= '0;
      raw_q    <= 5'd1;
      fin_q    <= '0;
      hit_q    <= 1'b0;
      crit_q   <= 1'b0;
      fum_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      pc_q     <= pc_d;
      retry_q  <= retry_d;
      face_q   <= face_d;
      second_q <= second_d;
      loaded_q <= loaded_d;
      mode_q   <= mode_d;
      mod_q    <= mod_d;
      tgt_q    <= tgt_d;
      vld_q    <= (state_q == S_EVAL);
      if (state_q == S_EVAL) begin
        raw_q  <= face_q;
        fin_q  <= sat;
        hit_q  <= hit_c;
        crit_q <= (face_q == 5'd20);
        fum_q  <= (face_q == 5'd1);
      end
    end
  end

  assign loaded     = loaded_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_READY);
  assign roll_valid = vld_q;
  assign roll_raw   = raw_q;
  assign roll_final = fin_q;
  assign hit        = hit_q;
  assign crit       = crit_q;
  assign fumble     = fum_q;

endmodule

// File: tb/tb_roll_sequencer.sv
// tb_roll_sequencer: drives loads and rolls, models the memory and the
// d20 rules at a high level, and scoreboards results and fetch addresses.
module tb_roll_sequencer;

  localparam int DEPTH = 32;
  localparam int RETRY = 3;

  logic       clk, reset;
  logic       load_start, load_valid, roll_req;
  logic [4:0] load_data, mem_rdata, mem_wdata, roll_raw;
  logic [1:0] mode;
  logic [7:0] mod, target, roll_final;
  logic       mem_we, mem_re, loaded, busy, roll_valid;
  logic       hit, crit, fumble;
  logic [4:0] mem_addr;

  roll_sequencer dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .roll_req(roll_req),
    .mode(mode), .mod(mod), .target(target),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .loaded(loaded), .busy(busy), .roll_valid(roll_valid),
    .roll_raw(roll_raw), .roll_final(roll_final),
    .hit(hit), .crit(crit), .fumble(fumble)
  );

  typedef struct {
    int raw; int fin; int hit; int crit; int fum; int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   addr_q[$];
  int   img[DEPTH];
  int   mdl[DEPTH];
  int   mpc;
  int   cyc;
  int   we_cnt;
  int   n_cmp, n_bad;
  logic [4:0] mem [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory instance: synchronous write, read data one cycle after mem_re
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int die(inout int fetches);
    int v;
    v = 0;
    for (int k = 0; k <= RETRY; k++) begin
      v = mdl[mpc];
      addr_q.push_back(mpc);
      mpc = (mpc + 1) % DEPTH;
      fetches++;
      if (v < 20) return v + 1;
    end
    return v - 19;
  endfunction

  function automatic exp_t model_roll(input int m, input int md, input int tg);
    exp_t e;
    int f, g, s;
    int fetches = 0;
    f = die(fetches);
    if (m == 1 || m == 2) begin
      g = die(fetches);
      if (m == 1) f = (g > f) ? g : f;
      else        f = (g < f) ? g : f;
    end
    s = f + md;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    e.raw  = f;
    e.fin  = s;
    e.hit  = (f == 20) ? 1 : (f == 1) ? 0 : int'(s >= tg);
    e.crit = int'(f == 20);
    e.fum  = int'(f == 1);
    e.cyc  = cyc + 2 * fetches + 2;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) we_cnt++;
      if (mem_we && mem_re) begin
        n_cmp++; n_bad++;
        $display("FAIL we_re_both: got we=1 re=1, expected exclusive");
      end
      if (mem_re) begin
        if (addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL stray_fetch: got mem_re at addr %0d, expected none",
                   mem_addr);
        end else check("fetch_addr", int'(mem_addr), addr_q.pop_front());
      end
      if (roll_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL stray_valid: got roll_valid, expected none");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("roll_raw", int'(roll_raw), e.raw);
          check("roll_final", int'($signed(roll_final)), e.fin);
          check("hit", int'(hit), e.hit);
          check("crit", int'(crit), e.crit);
          check("fumble", int'(fumble), e.fum);
          check("latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
    end
  endtask

  task automatic load_mem(input bit gap, input bit poke);
    wait_idle();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("loaded_cleared", int'(loaded), 0);
    we_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gap && i > 0) begin
        load_valid = 1'b0;
        roll_req   = poke;
        @(posedge clk); #1;
        roll_req   = 1'b0;
      end
      load_valid = 1'b1;
      load_data  = 5'(img[i]);
      #1;
      if (i == 0 || i == DEPTH - 1) begin
        check("wr_we", int'(mem_we), 1);
        check("wr_addr", int'(mem_addr), i);
        check("wr_data", int'(mem_wdata), img[i]);
        check("load_busy", int'(busy), 1);
      end
      if (i == DEPTH - 1) check("loaded_early", int'(loaded), 0);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    check("loaded_rise", int'(loaded), 1);
    check("we_count", we_cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) mdl[i] = img[i];
    mpc = 0;
  endtask

  task automatic do_roll(input int m, input int md, input int tg, input bit hold);
    exp_t e;
    wait_idle();
    e = model_roll(m, md, tg);
    sb_q.push_back(e);
    roll_req = 1'b1;
    mode     = 2'(m);
    mod      = 8'(md);
    target   = 8'(tg);
    @(posedge clk); #1;
    mod    = 8'($urandom);
    target = 8'($urandom);
    mode   = 2'($urandom);
    if (hold) begin
      @(posedge clk); #1;
    end
    roll_req = 1'b0;
  endtask

  task automatic fill_rand(input int hi);
    for (int i = 0; i < DEPTH; i++) img[i] = int'($urandom_range(hi));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; we_cnt = 0; mpc = 0;
    reset = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_data = 5'd0;
    roll_req = 1'b0; mode = 2'd0; mod = 8'd0; target = 8'd0;
    repeat (2) @(posedge clk); #1;
    check("rst_busy", int'(busy), 0);
    check("rst_loaded", int'(loaded), 0);
    check("rst_valid", int'(roll_valid), 0);
    check("rst_raw", int'(roll_raw), 1);
    check("rst_final", int'(roll_final), 0);
    check("rst_flags", int'({hit, crit, fumble}), 0);
    check("rst_mem", int'({mem_we, mem_re, mem_addr}), 0);
    reset = 1'b1;
    roll_req = 1'b1;
    @(posedge clk); #1;
    roll_req = 1'b0;
    check("idle_unloaded", int'(busy), 0);

    for (int i = 0; i < DEPTH; i++) img[i] = i % 20;
    load_mem(1'b1, 1'b1);
    do_roll(0, 5, 10, 1'b0);
    do_roll(0, -3, 10, 1'b0);

    fill_rand(19); img[0] = 25; img[1] = 13;
    load_mem(1'b0, 1'b0);
    do_roll(0, 0, 10, 1'b0);

    fill_rand(19); img[0] = 3; img[1] = 8;
    load_mem(1'b0, 1'b0);
    do_roll(1, 2, 10, 1'b0);
    load_mem(1'b0, 1'b0);
    do_roll(2, 2, 10, 1'b0);

    fill_rand(19); img[0] = 19; img[1] = 0;
    load_mem(1'b0, 1'b0);
    do_roll(0, 127, 127, 1'b0);
    do_roll(0, -128, -128, 1'b0);

    fill_rand(19);
    for (int i = 0; i < 4; i++) img[i] = 31;
    load_mem(1'b0, 1'b0);
    do_roll(0, 0, 0, 1'b0);

    fill_rand(19);
    load_mem(1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++)
      do_roll(0, int'($urandom_range(255)) - 128,
              int'($urandom_range(255)) - 128, 1'b0);

    fill_rand(31);
    load_mem(1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      do_roll(int'($urandom_range(3)), int'($urandom_range(255)) - 128,
              int'($urandom_range(40)) - 10, 1'($urandom));
    wait_idle();

    fill_rand(19);
    load_mem(1'b0, 1'b0);
    do_roll(0, 10, 0, 1'b0);
    wait_idle();
    addr_q.push_back(mpc);
    roll_req = 1'b1; mode = 2'd0;
    @(posedge clk); #1;
    roll_req = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    sb_q.delete();
    check("midrst_busy", int'(busy), 0);
    check("midrst_re", int'(mem_re), 0);
    check("midrst_raw", int'(roll_raw), 1);
    check("midrst_final", int'(roll_final), 0);
    check("midrst_flags", int'({hit, crit, fumble, roll_valid}), 0);
    check("midrst_loaded", int'(loaded), 0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_valid", int'(roll_valid), 0);

    check("sb_drained", sb_q.size(), 0);
    check("fetch_drained", addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
